// File: rtl/video_frame_monitor.sv
// Frame monitor: line/frame geometry, per-frame pixel CRC (VFM_CRC_EN) and line-length stability check.
// Latency: a sync fall sampled in cycle N gives frame_done and new results in cycle N+1.
// Backpressure: none; results are held until the next frame close, done is sticky until reset.
module video_frame_monitor #(
  parameter int COLOR_W    = 3,
  parameter int CNT_W      = 12,
  parameter int NUM_FRAMES = 3
) (
  input  logic                 clock,
  input  logic                 reset_N,
  input  logic                 pix_ce,
  input  logic [COLOR_W-1:0]   R,
  input  logic [COLOR_W-1:0]   G,
  input  logic [COLOR_W-1:0]   B,
  input  logic                 HSYNC_n,
  input  logic                 VSYNC_n,
  output logic                 frame_done,
  output logic [7:0]           frame_idx,
  output logic [CNT_W-1:0]     lines,
  output logic [CNT_W-1:0]     line_len,
  output logic [2*CNT_W-1:0]   active_px,
  output logic [31:0]          crc,
  output logic                 len_err,
  output logic                 done
);

  localparam int FC_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                hs_q, vs_q;
  logic                hs_fall, vs_fall;
  logic                pix_act;
  logic                frame_start, frame_close, last_close, restart;

  logic [CNT_W-1:0]    line_cnt;
  logic [CNT_W-1:0]    px_cnt;
  logic [2*CNT_W-1:0]  act;
  logic [CNT_W-1:0]    ref_len;
  logic                ref_valid;
  logic                err;
  logic [7:0]          fcnt;
  logic [FC_W-1:0]     nclosed;

  assign hs_fall     = !HSYNC_n && hs_q;
  assign vs_fall     = !VSYNC_n && vs_q;
  assign pix_act     = pix_ce && HSYNC_n && VSYNC_n;
  assign frame_start = (state == IDLE) && vs_fall;
  assign frame_close = (state == CAPTURE) && vs_fall;
  assign last_close  = frame_close && (nclosed == FC_W'(NUM_FRAMES - 1));
  // A close re-arms the accumulators exactly like the first start does.
  assign restart     = frame_start || frame_close;

  // Sync history for fall detection, sampled every clock regardless of pix_ce.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      hs_q <= HSYNC_n;
      vs_q <= VSYNC_n;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: IDLE waits for a frame start, CAPTURE runs until the last close.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_fall) state_nxt = CAPTURE;
      CAPTURE: if (last_close) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working accumulators. On a restart this cycle's events already belong to the
  // new frame: an HSYNC fall is its line 1 and a pix_ce is the first pixel count.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      line_cnt  <= '0;
      px_cnt    <= '0;
      act       <= '0;
      ref_len   <= '0;
      ref_valid <= 1'b0;
      err       <= 1'b0;
    end else if (restart) begin
      line_cnt  <= {{(CNT_W-1){1'b0}}, hs_fall};
      px_cnt    <= {{(CNT_W-1){1'b0}}, pix_ce};
      act       <= {{(2*CNT_W-1){1'b0}}, pix_act};
      ref_len   <= '0;
      ref_valid <= 1'b0;
      err       <= 1'b0;
    end else if (state == CAPTURE) begin
      if (pix_ce && (px_cnt != '1)) px_cnt <= px_cnt + 1'b1;
      if (pix_act && (act != '1))   act    <= act + 1'b1;
      if (hs_fall) begin
        if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
        // The fall cycle's own pixel starts the next line.
        px_cnt <= {{(CNT_W-1){1'b0}}, pix_ce};
        // Only falls after the first bound a complete line.
        if (line_cnt != '0) begin
          if (!ref_valid) begin
            ref_len   <= px_cnt;
            ref_valid <= 1'b1;
          end else if (px_cnt != ref_len) begin
            err <= 1'b1;
          end
        end
      end
    end
  end

  // Result registers, frame index and completion tracking, updated on frame close.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      frame_done <= 1'b0;
      frame_idx  <= '0;
      lines      <= '0;
      line_len   <= '0;
      active_px  <= '0;
      len_err    <= 1'b0;
      done       <= 1'b0;
      fcnt       <= '0;
      nclosed    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (frame_close) begin
        frame_done <= 1'b1;
        frame_idx  <= fcnt;
        fcnt       <= fcnt + 1'b1;
        lines      <= line_cnt;
        line_len   <= ref_valid ? ref_len : '0;
        active_px  <= act;
        len_err    <= err;
        if (last_close) done    <= 1'b1;
        else            nclosed <= nclosed + 1'b1;
      end
    end
  end

`ifdef VFM_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  logic [3*COLOR_W-1:0] pix_word;
  logic [31:0]          crc_acc;

  assign pix_word = {R, G, B};

  // One CRC-32 update of a whole pixel word, MSB first, unreflected.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3*COLOR_W-1:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 3*COLOR_W-1; i >= 0; i--) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

  // CRC accumulator and its latched per-frame result.
  always_ff @(posedge clock or negedge reset_N) begin
    if (!reset_N) begin
      crc_acc <= '1;
      crc     <= '0;
    end else begin
      if (frame_close) crc <= crc_acc;
      if (restart)
        crc_acc <= pix_act ? crc_step(32'hFFFFFFFF, pix_word) : 32'hFFFFFFFF;
      else if ((state == CAPTURE) && pix_act)
        crc_acc <= crc_step(crc_acc, pix_word);
    end
  end
`else
  // Colour inputs only feed the CRC, which is absent in this build.
  logic unused_pix;
  assign unused_pix = ^{R, G, B};
  assign crc        = 32'd0;
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
// Directed bench for video_frame_monitor: geometry, line-length error, CRC,
// coincident sync falls, NUM_FRAMES completion and mid-frame reset.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
module tb_video_frame_monitor;

  localparam int COLOR_W = 3;
  localparam int CNT_W   = 12;

  logic                clock = 1'b0;
  logic                reset_N;
  logic                pix_ce;
  logic [COLOR_W-1:0]  R, G, B;
  logic                HSYNC_n, VSYNC_n;
  logic                frame_done;
  logic [7:0]          frame_idx;
  logic [CNT_W-1:0]    lines;
  logic [CNT_W-1:0]    line_len;
  logic [2*CNT_W-1:0]  active_px;
  logic [31:0]         crc;
  logic                len_err;
  logic                done;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  logic [31:0] m_crc;
  logic [31:0] saved_crc;

  video_frame_monitor #(.COLOR_W(COLOR_W), .CNT_W(CNT_W), .NUM_FRAMES(3)) dut (
    .clock      (clock),
    .reset_N    (reset_N),
    .pix_ce     (pix_ce),
    .R          (R),
    .G          (G),
    .B          (B),
    .HSYNC_n    (HSYNC_n),
    .VSYNC_n    (VSYNC_n),
    .frame_done (frame_done),
    .frame_idx  (frame_idx),
    .lines      (lines),
    .line_len   (line_len),
    .active_px  (active_px),
    .crc        (crc),
    .len_err    (len_err),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Count frame_done pulses away from the active edge.
  always @(negedge clock) if (frame_done === 1'b1) fd_cnt++;

  // Reference CRC-32: poly 04C11DB7, MSB-first, no reflection, no final XOR.
  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [8:0] w);
    logic [31:0] r;
    r = c;
    for (int i = 8; i >= 0; i--)
      r = (r << 1) ^ (((r[31] ^ w[i]) == 1'b1) ? 32'h04C11DB7 : 32'h0);
    return r;
  endfunction

  function automatic logic [31:0] exp_crc(input logic [31:0] model);
`ifdef VFM_CRC_EN
    return model;
`else
    return (model & 32'h0);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; active pixels also feed the CRC model.
  task automatic step(input logic hs, input logic vs, input logic ce, input logic [8:0] px);
    HSYNC_n = hs;
    VSYNC_n = vs;
    pix_ce  = ce;
    R = px[8:6];
    G = px[5:3];
    B = px[2:0];
    if (ce && hs && vs) m_crc = crc_ref(m_crc, px);
    @(posedge clock);
    #1;
  endtask

  // One line: HSYNC low for (len-nact) pix_ce cycles, then nact active pixels.
  // gap inserts a pix_ce=0 cycle after each active pixel.
  task automatic line(input int len, input int nact, input bit gap, input logic [8:0] base);
    for (int i = 0; i < len - nact; i++) step(1'b0, 1'b1, 1'b1, 9'h0);
    for (int i = 0; i < nact; i++) begin
      step(1'b1, 1'b1, 1'b1, base + 9'(i));
      if (gap) step(1'b1, 1'b1, 1'b0, 9'h0);
    end
  endtask

  task automatic vsync_fall();
    step(1'b1, 1'b0, 1'b0, 9'h0);
  endtask

  initial begin
    reset_N = 1'b0;
    pix_ce  = 1'b0;
    HSYNC_n = 1'b1;
    VSYNC_n = 1'b1;
    R = '0; G = '0; B = '0;
    m_crc = 32'hFFFFFFFF;
    saved_crc = 32'h0;
    #22;
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_idx",  frame_idx,  0);
    chk("rst_lines",      lines,      0);
    chk("rst_line_len",   line_len,   0);
    chk("rst_active_px",  active_px,  0);
    chk("rst_crc",        crc,        0);
    chk("rst_len_err",    len_err,    0);
    chk("rst_done",       done,       0);
    @(posedge clock);
    #1;
    reset_N = 1'b1;
    step(1'b1, 1'b1, 1'b0, 9'h0);

    // Partial frame after reset, discarded; its closing VSYNC fall only starts capture.
    line(10, 8, 1'b0, 9'h011);
    line(10, 8, 1'b0, 9'h022);
    vsync_fall();
    chk("start_no_frame_done", frame_done, 0);
    m_crc = 32'hFFFFFFFF;
    step(1'b1, 1'b1, 1'b0, 9'h0);

    // Frame 0: 4 lines of 10, 8 active each, all-zero pixels.
    for (int l = 0; l < 4; l++) line(10, 8, 1'b0, 9'h000);
    vsync_fall();
    chk("f0_frame_done", frame_done, 1);
    chk("f0_frame_idx",  frame_idx,  0);
    chk("f0_lines",      lines,      4);
    chk("f0_line_len",   line_len,   10);
    chk("f0_active_px",  active_px,  32);
    chk("f0_len_err",    len_err,    0);
    chk("f0_crc",        crc,        exp_crc(m_crc));
    chk("f0_done",       done,       0);
    m_crc = 32'hFFFFFFFF;
    step(1'b1, 1'b1, 1'b0, 9'h0);
    chk("f0_pulse_width", frame_done, 0);
    chk("f0_hold_lines",  lines,      4);

    // Frame 1: pix_ce gaps on line 1, line 3 is 11 long, closed by HSYNC+VSYNC together.
    line(10, 8, 1'b1, 9'h1A0);
    line(10, 8, 1'b0, 9'h055);
    line(11, 8, 1'b0, 9'h100);
    line(10, 8, 1'b0, 9'h0F0);
    step(1'b0, 1'b0, 1'b1, 9'h0);
    chk("f1_frame_done", frame_done, 1);
    chk("f1_frame_idx",  frame_idx,  1);
    chk("f1_lines",      lines,      4);
    chk("f1_line_len",   line_len,   10);
    chk("f1_active_px",  active_px,  32);
    chk("f1_len_err",    len_err,    1);
    chk("f1_crc",        crc,        exp_crc(m_crc));
    chk("f1_done",       done,       0);
    m_crc = 32'hFFFFFFFF;

    // Frame 2: the coincident HSYNC fall is its line 1 (10 long), then 2 more lines.
    step(1'b0, 1'b0, 1'b1, 9'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 9'h07F + 9'(i));
    line(10, 8, 1'b0, 9'h1F8);
    line(10, 8, 1'b0, 9'h0C3);
    vsync_fall();
    chk("f2_frame_done", frame_done, 1);
    chk("f2_frame_idx",  frame_idx,  2);
    chk("f2_lines",      lines,      3);
    chk("f2_line_len",   line_len,   10);
    chk("f2_active_px",  active_px,  24);
    chk("f2_len_err",    len_err,    0);
    chk("f2_crc",        crc,        exp_crc(m_crc));
    chk("f2_done",       done,       1);
    saved_crc = exp_crc(m_crc);
    step(1'b1, 1'b1, 1'b0, 9'h0);

    // Frames 4 and 5 after DONE: ignored, results held.
    for (int f = 0; f < 2; f++) begin
      line(12, 6, 1'b0, 9'h1E0);
      line(12, 6, 1'b0, 9'h0AB);
      vsync_fall();
      chk("post_done_no_pulse", frame_done, 0);
      step(1'b1, 1'b1, 1'b0, 9'h0);
    end
    chk("hold_frame_idx", frame_idx, 2);
    chk("hold_lines",     lines,     3);
    chk("hold_active_px", active_px, 24);
    chk("hold_line_len",  line_len,  10);
    chk("hold_crc",       crc,       saved_crc);
    chk("hold_done",      done,      1);
    chk("pulse_count",    fd_cnt,    3);

    // Mid-frame reset for one cycle: outputs clear at once, no clock edge needed.
    line(10, 8, 1'b0, 9'h033);
    reset_N = 1'b0;
    #1;
    chk("arst_done",      done,      0);
    chk("arst_lines",     lines,     0);
    chk("arst_frame_idx", frame_idx, 0);
    chk("arst_active_px", active_px, 0);
    chk("arst_line_len",  line_len,  0);
    chk("arst_crc",       crc,       0);
    @(posedge clock);
    #1;
    reset_N = 1'b1;
    line(10, 8, 1'b0, 9'h044);
    vsync_fall();
    chk("arst_start_no_pulse", frame_done, 0);
    m_crc = 32'hFFFFFFFF;
    step(1'b1, 1'b1, 1'b0, 9'h0);
    chk("arst_pulse_count", fd_cnt, 3);

    // First full frame after the reset is reported as frame 0 again.
    line(9, 7, 1'b0, 9'h101);
    line(9, 7, 1'b0, 9'h0EE);
    vsync_fall();
    chk("r0_frame_done", frame_done, 1);
    chk("r0_frame_idx",  frame_idx,  0);
    chk("r0_lines",      lines,      2);
    chk("r0_line_len",   line_len,   9);
    chk("r0_active_px",  active_px,  14);
    chk("r0_crc",        crc,        exp_crc(m_crc));
    step(1'b1, 1'b1, 1'b0, 9'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_frame_monitor.md
# video_frame_monitor

Synthesizable frame monitor that sits on the VCE output (VIDEO_R/G/B plus HSYNC_n/VSYNC_n) in place of the file-logging bench loop. It measures line and frame geometry, computes a per-frame pixel CRC and checks line-length stability for a parametrised number of frames. Results are exposed as registered outputs, so benches and on-chip debug logic can compare whole frames without dumping pixels.

## Interface
- COLOR_W, 3: bits per colour channel.
- CNT_W, 12: width of the pixel and line counters.
- NUM_FRAMES, 3: complete frames to capture before entering DONE.
- clock  in  1  system clock.
- reset_N  in  1  asynchronous, active-low reset.
- pix_ce  in  1  pixel clock enable; a pixel is sampled only on clocks where it is 1.
- R, G, B  in  COLOR_W each  pixel colour.
- HSYNC_n, VSYNC_n  in  1  active-low syncs.
- frame_done  out  1  one-cycle pulse when a frame's results are latched.
- frame_idx  out  8  index of the frame just latched, 0-based; wraps at 255.
- lines  out  CNT_W  HSYNC_n falling edges in the frame.
- line_len  out  CNT_W  pix_ce count of the reference line.
- active_px  out  2*CNT_W  active pixels in the frame.
- crc  out  32  pixel CRC of the frame.
- len_err  out  1  a complete line in the frame differed from line_len.
- done  out  1  NUM_FRAMES frames latched; sticky until reset.

## Operation
- Edge detect: registered copies hs_q and vs_q, both reset to 1. A fall is sync==0 && q==1, evaluated every clock regardless of pix_ce.
- States:
  - IDLE (reset state): waits for a VSYNC fall. The partial frame after reset is discarded.
  - CAPTURE: accumulates frame data.
  - DONE: terminal; inputs are ignored.
- IDLE to CAPTURE on a VSYNC fall. The working accumulators are cleared: line_cnt=0, px_cnt=0, act=0, crc_acc=0xFFFFFFFF, ref_valid=0, err=0.
- In CAPTURE:
  - Each pix_ce cycle increments px_cnt.
  - Each pix_ce cycle with HSYNC_n=1 and VSYNC_n=1 is an active pixel. It increments act and updates crc_acc.
  - On an HSYNC fall, line_cnt increments. If this is not the first fall of the frame, px_cnt is a complete-line length:
    - if ref_valid=0, store it as ref_len and set ref_valid;
    - otherwise a mismatch with ref_len sets err.
  - px_cnt is cleared on every HSYNC fall.
- On a VSYNC fall in CAPTURE, the frame closes:
  - lines<=line_cnt, line_len<=ref_len (0 if no complete line), active_px<=act, crc<=crc_acc, len_err<=err.
  - frame_done pulses; frame_idx increments (the first latched frame reads 0).
  - The accumulators are re-cleared in the same cycle.
  - After the NUM_FRAMES-th close, go to DONE and set done.
- CRC: CRC-32, polynomial 0x04C11DB7, initial value 0xFFFFFFFF, no reflection, no final XOR. One word {R,G,B} (3*COLOR_W bits, R MSB) is folded per active pixel, MSB first, in a single cycle.
- All counters saturate at all-ones, never wrap. frame_idx is the only wrapping counter.
- Simultaneous events:
  - HSYNC fall and VSYNC fall in the same cycle: close the frame first; the HSYNC fall counts as line 1 of the new frame.
  - Active pixel coincident with the frame close: it belongs to the new frame.

## Timing
- Outputs are registered; all are 0 after reset.
- Latency: the fall is detected in cycle N, and frame_done and the new results are visible in cycle N+1. Results hold until the next close.
- Reset mid-frame: returns to IDLE asynchronously; the partial frame is never reported.
- No backpressure: the consumer must sample during the frame_done cycle or from the held outputs.

## Configuration
- VFM_CRC_EN defined: CRC logic is present as described.
- VFM_CRC_EN undefined: no CRC logic; crc reads constant 0. All other behaviour is unchanged.

## Test plan
- Reset, then 2 lines, then a VSYNC fall (to discard the partial frame). Then 4 lines of 10 pix_ce each with 8 active, then a VSYNC fall -> frame_done one cycle later, frame_idx=0, lines=4, line_len=10, active_px=32, len_err=0.
- Same frame but line 3 is 11 pixels long -> len_err=1, line_len=10.
- All active pixels R=G=B=0, VFM_CRC_EN on -> crc equals a software CRC-32 (polynomial, init and bit order as in Operation) over the same count of 9-bit zero words. With VFM_CRC_EN off -> crc=0.
- HSYNC and VSYNC fall in the same cycle -> the closing frame's lines excludes that edge, and the next frame counts it as line 1.
- NUM_FRAMES=3, 5 frames driven -> frame_done pulses exactly 3 times and done=1 after the third. The held outputs are not disturbed by frames 4 and 5.
- Assert reset_N low mid-frame for 1 cycle -> all outputs 0 immediately. The next VSYNC fall only starts capture and produces no frame_done.
